// File: rtl/cvp_pkg.sv
// Shared CVP vector-core definitions: op encodings, sequencer state codes
// and the opcode constants the core decoder uses to dispatch vector memory ops.
package cvp_pkg;

   localparam logic OP_VLD = 1'b0;
   localparam logic OP_VST = 1'b1;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_IDLE      = 3'd0;
   localparam seq_state_t ST_LOAD      = 3'd1;
   localparam seq_state_t ST_LOAD_TAIL = 3'd2;
   localparam seq_state_t ST_STORE     = 3'd3;
   localparam seq_state_t ST_DONE      = 3'd4;

   localparam logic [6:0] CVP_OPC_VLD = 7'h07;
   localparam logic [6:0] CVP_OPC_VST = 7'h27;

endpackage

// File: rtl/vec_addr_gen.sv
// Element address generator: holds the current address, accumulates the
// stride per step and flags (sticky) any carry out of the address space.
module vec_addr_gen #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] stride,
   output logic [AW-1:0] addr,
   output logic          wrap
);
   import cvp_pkg::*;

   logic [AW-1:0] stride_q;
   logic [AW:0]   sum;

   assign sum = {1'b0, addr} + {1'b0, stride_q};

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values and simulation order cannot change the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= '0;
         stride_q <= '0;
         wrap     <= 1'b0;
      end else if (load) begin
         addr     <= base;
         stride_q <= stride;
         wrap     <= 1'b0;
      end else if (step) begin
         addr <= sum[AW-1:0];
         if (sum[AW]) wrap <= 1'b1;
      end
   end

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: streams one VLEN-element vector between memory
// and a vector register, one element per cycle, at Base + i*Stride.
module vec_mem_seq #(
   parameter int DW        = 16,
   parameter int AW        = 16,
   parameter int VLEN      = 16,
   parameter int IDXW      = $clog2(VLEN),
   parameter int STRIDE_EN = 1
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic            Start,
   input  logic            Op,
   input  logic            Abort,
   input  logic [AW-1:0]   Base,
   input  logic [AW-1:0]   Stride,
   output logic            Busy,
   output logic            Done,
   output logic            AddrWrap,
   output logic [AW-1:0]   Addr,
   output logic            RD,
   output logic            WR,
   input  logic [DW-1:0]   DataIn,
   output logic [DW-1:0]   DataOut,
   output logic [IDXW-1:0] vRdIdx,
   input  logic [DW-1:0]   vRdData,
   output logic            vWR,
   output logic [IDXW-1:0] vWrIdx,
   output logic [DW-1:0]   vWrData
);
   import cvp_pkg::*;

   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(VLEN - 1);

   seq_state_t      state, state_nxt;
   logic [IDXW-1:0] idx;
   logic [AW-1:0]   stride_eff;
   logic            accept, active, last, advance;
   logic            vwr_q;
   logic [IDXW-1:0] vwr_idx_q;

   assign accept     = (state == ST_IDLE) & Start & ~Abort;
   assign active     = (state == ST_LOAD) | (state == ST_STORE);
   assign last       = (idx == IDX_LAST);
   // The address stops on the final element so AddrWrap only reflects addresses used.
   assign advance    = active & ~last & ~Abort;
   assign stride_eff = (STRIDE_EN != 0) ? Stride : AW'(1);

   vec_addr_gen #(.AW(AW)) u_addr_gen (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .load   (accept),
      .step   (advance),
      .base   (Base),
      .stride (stride_eff),
      .addr   (Addr),
      .wrap   (AddrWrap)
   );

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (accept) state_nxt = (Op == OP_VST) ? ST_STORE : ST_LOAD;
         ST_LOAD:      if (Abort) state_nxt = ST_IDLE;
                       else if (last) state_nxt = ST_LOAD_TAIL;
         ST_LOAD_TAIL: state_nxt = Abort ? ST_IDLE : ST_DONE;
         ST_STORE:     if (Abort) state_nxt = ST_IDLE;
                       else if (last) state_nxt = ST_DONE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         vwr_q     <= 1'b0;
         vwr_idx_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept)       idx <= '0;
         else if (advance) idx <= idx + IDXW'(1);
         // Load write-back trails the read by one cycle; Abort kills the in-flight element.
         vwr_q     <= (state == ST_LOAD) & ~Abort;
         vwr_idx_q <= idx;
      end
   end

   assign Busy    = (state != ST_IDLE);
   assign Done    = (state == ST_DONE) & ~Abort;
   assign RD      = (state == ST_LOAD);
   assign WR      = (state == ST_STORE);
   assign vRdIdx  = WR ? idx : '0;
   assign DataOut = WR ? vRdData : '0;
   assign vWR     = vwr_q;
   assign vWrIdx  = vwr_idx_q;
   assign vWrData = vwr_q ? DataIn : '0;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: loads, stores, strides, address wrap,
// abort, ignored starts, async reset, plus a STRIDE_EN=0 instance.
module tb_vec_mem_seq;

   logic        Clk, Reset_n, Start, Op, Abort;
   logic [15:0] Base, Stride, DataIn;

   logic        Busy, Done, AddrWrap, RD, WR, vWR;
   logic [15:0] Addr, DataOut, vRdData, vWrData;
   logic [3:0]  vRdIdx, vWrIdx;

   logic        b_busy, b_done, b_wrap, b_rd, b_wr, b_vwr;
   logic [15:0] b_addr, b_dout, b_vrddata, b_vwrdata;
   logic [3:0]  b_vrdidx, b_vwridx;

   logic [15:0] vreg [16];
   int          n_checks = 0;
   int          n_fail   = 0;

   vec_mem_seq dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .Abort(Abort),
      .Base(Base), .Stride(Stride), .Busy(Busy), .Done(Done), .AddrWrap(AddrWrap),
      .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn), .DataOut(DataOut),
      .vRdIdx(vRdIdx), .vRdData(vRdData), .vWR(vWR), .vWrIdx(vWrIdx), .vWrData(vWrData)
   );

   vec_mem_seq #(.STRIDE_EN(0)) dut_ns (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .Abort(Abort),
      .Base(Base), .Stride(Stride), .Busy(b_busy), .Done(b_done), .AddrWrap(b_wrap),
      .Addr(b_addr), .RD(b_rd), .WR(b_wr), .DataIn(DataIn), .DataOut(b_dout),
      .vRdIdx(b_vrdidx), .vRdData(b_vrddata), .vWR(b_vwr), .vWrIdx(b_vwridx), .vWrData(b_vwrdata)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous memory: content is a fixed function of the address.
   always @(posedge Clk) if (RD) DataIn <= Addr ^ 16'h5A5A;

   assign vRdData   = vreg[vRdIdx];
   assign b_vrddata = vreg[b_vrdidx];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_vld(input logic [15:0] base, input logic [15:0] stride,
                          input int abort_cyc, input logic exp_wrap);
      logic [15:0] ea, ed;
      logic        erd, evwr, edone, ebusy, aborted;
      Start = 1'b1; Op = 1'b0; Base = base; Stride = stride;
      tick();
      Start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         aborted = (abort_cyc > 0) && (c > abort_cyc);
         erd   = (c <= 16) && !aborted;
         evwr  = (c >= 2) && (c <= 17) && !aborted;
         edone = (c == 18) && !aborted;
         ebusy = (c <= 18) && !aborted;
         ea = base + 16'(int'(stride) * (c - 1));
         ed = (base + 16'(int'(stride) * (c - 2))) ^ 16'h5A5A;
         check("vld_rd",   32'(RD),   32'(erd));
         check("vld_vwr",  32'(vWR),  32'(evwr));
         check("vld_done", 32'(Done), 32'(edone));
         check("vld_busy", 32'(Busy), 32'(ebusy));
         if (erd)  check("vld_addr", 32'(Addr), 32'(ea));
         if (evwr) begin
            check("vld_vwridx", 32'(vWrIdx), 32'(c - 2));
            check("vld_vwrdata", 32'(vWrData), 32'(ed));
         end
         if (c == 1) check("vld_wrap_clr", 32'(AddrWrap), 32'(0));
         if (c >= 18 && abort_cyc <= 0) check("vld_wrap", 32'(AddrWrap), 32'(exp_wrap));
         Abort = (c == abort_cyc);
         if (aborted) break;
         tick();
      end
      Abort = 1'b0;
      tick();
   endtask

   task automatic run_vst(input logic [15:0] base, input logic [15:0] stride,
                          input logic start_mid, input logic exp_wrap);
      logic [15:0] ea, eb;
      Start = 1'b1; Op = 1'b1; Base = base; Stride = stride;
      tick();
      Start = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         ea = base + 16'(int'(stride) * (c - 1));
         eb = base + 16'(c - 1);
         check("vst_wr",   32'(WR),   32'(c <= 16));
         check("vst_done", 32'(Done), 32'(c == 17));
         check("vst_busy", 32'(Busy), 32'(c <= 17));
         if (c <= 16) begin
            check("vst_addr",  32'(Addr),    32'(ea));
            check("vst_ridx",  32'(vRdIdx),  32'(c - 1));
            check("vst_dout",  32'(DataOut), 32'((c - 1) * 3));
            check("vst_ns_wr", 32'(b_wr),    32'(1));
            check("vst_ns_addr", 32'(b_addr), 32'(eb));
         end
         if (c == 1)  check("vst_wrap_clr", 32'(AddrWrap), 32'(0));
         if (c == 17) check("vst_wrap", 32'(AddrWrap), 32'(exp_wrap));
         Start = start_mid && (c == 5);
         Op    = (c == 5) ? 1'b0 : 1'b1;
         tick();
      end
      Start = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Op = 1'b0; Abort = 1'b0;
      Base = '0; Stride = '0;
      for (int i = 0; i < 16; i++) vreg[i] = 16'(i * 3);
      #12;
      check("rst_busy", 32'(Busy), 32'(0));
      check("rst_addr", 32'(Addr), 32'(0));
      check("rst_strobes", 32'({RD, WR, vWR, Done, AddrWrap}), 32'(0));
      check("rst_data", 32'({DataOut, vWrData}), 32'(0));
      check("rst_idx", 32'({vRdIdx, vWrIdx}), 32'(0));
      Reset_n = 1'b1;
      tick();

      run_vld(16'h0100, 16'd1, -1, 1'b0);
      run_vst(16'h0200, 16'd4, 1'b1, 1'b0);
      run_vld(16'hFFFE, 16'd1, -1, 1'b1);
      run_vld(16'h0100, 16'd1, 6, 1'b0);
      run_vld(16'h0600, 16'd3, -1, 1'b0);

      Start = 1'b1; Abort = 1'b1; Op = 1'b0; Base = 16'h0700;
      tick();
      Start = 1'b0; Abort = 1'b0;
      check("start_abort_busy", 32'(Busy), 32'(0));
      check("start_abort_rd", 32'(RD), 32'(0));
      tick();
      check("start_abort_busy2", 32'(Busy), 32'(0));

      run_vst(16'h0400, 16'd0, 1'b0, 1'b0);
      run_vst(16'h0500, 16'd7, 1'b0, 1'b0);

      Start = 1'b1; Op = 1'b0; Base = 16'h0300; Stride = 16'd1;
      tick();
      Start = 1'b0;
      repeat (8) tick();
      check("mid_rd", 32'(RD), 32'(1));
      check("mid_addr", 32'(Addr), 32'(16'h0308));
      #2 Reset_n = 1'b0;
      #1;
      check("arst_busy", 32'(Busy), 32'(0));
      check("arst_addr", 32'(Addr), 32'(0));
      check("arst_strobes", 32'({RD, WR, vWR, Done, AddrWrap}), 32'(0));
      check("arst_data", 32'({DataOut, vWrData}), 32'(0));
      check("arst_idx", 32'({vRdIdx, vWrIdx}), 32'(0));
      tick();
      Reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("post_rst_idle", 32'({Busy, Done, RD, vWR}), 32'(0));
      end

      run_vld(16'h0800, 16'd2, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
